// File: rtl/keypad_scan_4x4.sv
// keypad_scan_4x4: 4x4 matrix keypad scanner with per-scan debounce.
// Drives one column low at a time, samples the synchronised rows at the end
// of each column step, classifies every full scan as NONE / SINGLE / MULTI
// and debounces press and release over DEBOUNCE_SCANS consecutive scans.
// Optional macro KEYPAD_ACCUM_EN: N shifts in each accepted key code as a
// new low nibble; without it N is simply {4'h0, KEY}.
module keypad_scan_4x4 #(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       CLK,
    input  logic       RESETN,
    output logic [3:0] COL,
    input  logic [3:0] ROW,
    output logic [3:0] KEY,
    output logic       KEY_VALID,
    output logic       PRESSED,
    output logic [7:0] N
);

    localparam int unsigned   PW         = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [3:0]    DB_TARGET  = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DB_PRESS,
        S_HELD,
        S_DB_REL
    } state_t;

    typedef enum logic [1:0] {
        RES_NONE,
        RES_SINGLE,
        RES_MULTI
    } scan_res_t;

    // Row synchroniser
    logic [3:0]    row_meta;
    logic [3:0]    row_sync;

    // Column stepping
    logic [PW-1:0] presc;
    logic [1:0]    col_idx;
    logic          wrap;
    logic          scan_done;

    // Scan accumulation: hit count saturates at 2 (meaning "two or more")
    logic [1:0]    acc_hits;
    logic [3:0]    acc_code;
    logic [2:0]    col_hits;
    logic [1:0]    col_row;
    logic [2:0]    hits_sum;
    logic [1:0]    hits_merged;
    logic [3:0]    code_merged;
    scan_res_t     scan_res;

    // Debounce FSM and registered outputs
    state_t        state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic [3:0]    cand, cand_n;
    logic [3:0]    key_q, key_n;
    logic          kv_q, kv_n;
    logic          pressed_q, pressed_n;
`ifdef KEYPAD_ACCUM_EN
    logic [7:0]    n_q, n_n;
`endif

    assign wrap      = (presc == PRESC_LAST);
    assign scan_done = wrap && (col_idx == 2'd3);

    // Two-flop synchroniser for the asynchronous row inputs (idle high)
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= ROW;
            row_sync <= row_meta;
        end
    end

    // Prescaler and column index; the column advances on the wrap cycle
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            presc   <= '0;
            col_idx <= '0;
        end else if (wrap) begin
            presc   <= '0;
            col_idx <= col_idx + 2'd1;
        end else begin
            presc   <= presc + 1'b1;
        end
    end

    assign COL = ~(4'b0001 << col_idx);

    // Fold the current column's sample into the running scan totals
    always_comb begin
        col_hits = '0;
        col_row  = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            if (!row_sync[r]) begin
                col_hits = col_hits + 3'd1;
                col_row  = 2'(r);
            end
        end
        hits_sum    = {1'b0, acc_hits} + col_hits;
        hits_merged = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
        code_merged = (acc_hits != 2'd0) ? acc_code : {col_row, col_idx};
        case (hits_merged)
            2'd0:    scan_res = RES_NONE;
            2'd1:    scan_res = RES_SINGLE;
            default: scan_res = RES_MULTI;
        endcase
    end

    // Scan accumulator: updated on each column sample, cleared when the scan completes
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            acc_hits <= '0;
            acc_code <= '0;
        end else if (wrap) begin
            if (col_idx == 2'd3) begin
                acc_hits <= '0;
                acc_code <= '0;
            end else begin
                acc_hits <= hits_merged;
                acc_code <= code_merged;
            end
        end
    end

    // Debounce state register and registered outputs
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state     <= S_IDLE;
            cnt       <= '0;
            cand      <= '0;
            key_q     <= '0;
            kv_q      <= 1'b0;
            pressed_q <= 1'b0;
`ifdef KEYPAD_ACCUM_EN
            n_q       <= '0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cand      <= cand_n;
            key_q     <= key_n;
            kv_q      <= kv_n;
            pressed_q <= pressed_n;
`ifdef KEYPAD_ACCUM_EN
            n_q       <= n_n;
`endif
        end
    end

    // Next-state: transitions first, then acceptance once the count reaches target.
    // Acceptance is folded into the same evaluation so DEBOUNCE_SCANS=1 accepts
    // straight out of IDLE / HELD without an extra scan.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        cand_n    = cand;
        key_n     = key_q;
        kv_n      = 1'b0;
        pressed_n = pressed_q;
`ifdef KEYPAD_ACCUM_EN
        n_n       = n_q;
`endif
        if (scan_done) begin
            case (state)
                S_IDLE: begin
                    if (scan_res == RES_SINGLE) begin
                        state_n = S_DB_PRESS;
                        cand_n  = code_merged;
                        cnt_n   = 4'd1;
                    end
                end
                S_DB_PRESS: begin
                    if (scan_res == RES_SINGLE) begin
                        if (code_merged == cand) begin
                            cnt_n = cnt + 4'd1;
                        end else begin
                            cand_n = code_merged;
                            cnt_n  = 4'd1;
                        end
                    end else begin
                        state_n = S_IDLE;
                        cnt_n   = '0;
                    end
                end
                S_HELD: begin
                    if (scan_res == RES_NONE) begin
                        state_n = S_DB_REL;
                        cnt_n   = 4'd1;
                    end
                end
                S_DB_REL: begin
                    if (scan_res == RES_NONE) begin
                        cnt_n = cnt + 4'd1;
                    end else begin
                        state_n = S_HELD;
                        cnt_n   = '0;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end
            endcase

            if (state_n == S_DB_PRESS && cnt_n == DB_TARGET) begin
                state_n   = S_HELD;
                cnt_n     = '0;
                key_n     = cand_n;
                kv_n      = 1'b1;
                pressed_n = 1'b1;
`ifdef KEYPAD_ACCUM_EN
                n_n       = {n_q[3:0], cand_n};
`endif
            end else if (state_n == S_DB_REL && cnt_n == DB_TARGET) begin
                state_n   = S_IDLE;
                cnt_n     = '0;
                pressed_n = 1'b0;
            end
        end
    end

    assign KEY       = key_q;
    assign KEY_VALID = kv_q;
    assign PRESSED   = pressed_q;
`ifdef KEYPAD_ACCUM_EN
    assign N         = n_q;
`else
    assign N         = {4'h0, key_q};
`endif

endmodule
